// File: rtl/pulse_sync_rx_pkg.sv
// Shared types for the pulse-stretch receiver.
// State encoding and width-counter sizing helper.
package pulse_sync_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2
  } state_t;

  function automatic int w_width(input int max_high);
    return $clog2(max_high + 2);
  endfunction

endpackage

// File: rtl/pulse_sync_rx_if.sv
// Event/handshake bundle between the receiver and its consumer.
// master drives the level and control, slave is the receiver.
interface pulse_sync_rx_if #(
  parameter int PEND_W = 4,
  parameter int CNT_W  = 8
);
  logic              i_sync_lvl;
  logic              i_evt_ready;
  logic              i_err_clr;
  logic              o_pulse;
  logic              o_evt_valid;
  logic [PEND_W-1:0] o_pending;
  logic [CNT_W-1:0]  o_total;
  logic              o_err_short;
  logic              o_err_long;
  logic              o_err_ovf;
  logic              o_busy;

  modport master (
    output i_sync_lvl, i_evt_ready, i_err_clr,
    input  o_pulse, o_evt_valid, o_pending, o_total,
    input  o_err_short, o_err_long, o_err_ovf, o_busy
  );

  modport slave (
    input  i_sync_lvl, i_evt_ready, i_err_clr,
    output o_pulse, o_evt_valid, o_pending, o_total,
    output o_err_short, o_err_long, o_err_ovf, o_busy
  );
endinterface

// File: rtl/pulse_width_chk.sv
// Edge-to-event FSM with high-width measurement.
// Emits an event strobe on each rise and error strobes on bad widths.
module pulse_width_chk
  import pulse_sync_rx_pkg::*;
#(
  parameter int MIN_HIGH = 1,
  parameter int MAX_HIGH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic evt,
  output logic err_short,
  output logic err_long,
  output logic busy
);
  localparam int WW = w_width(MAX_HIGH);
  localparam logic [WW-1:0] W_MIN = WW'(MIN_HIGH);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_HIGH);
  localparam logic [WW-1:0] W_SAT = WW'(MAX_HIGH + 1);

  state_t        state_q, state_d;
  logic [WW-1:0] w_q, w_d;
  logic          prev_q;
  logic          busy_q;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    evt       = 1'b0;
    err_short = 1'b0;
    err_long  = 1'b0;
    unique case (1'b1)
      state_q == WAIT_LOW: begin
        if (!lvl) state_d = IDLE;
      end
      state_q == IDLE: begin
        if (lvl && !prev_q) begin
          evt     = 1'b1;
          w_d     = WW'(1);
          state_d = HIGH;
        end
      end
      state_q == HIGH: begin
        if (lvl) begin
          if (w_q == W_MAX) err_long = 1'b1;
          if (w_q != W_SAT) w_d = w_q + 1'b1;
        end else begin
          if (w_q < W_MIN) err_short = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_LOW;
      w_q     <= '0;
      prev_q  <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      prev_q  <= lvl;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/pulse_sync_rx.sv
// Slow-domain receiver for the pulse-stretch CDC.
// Turns stretched levels into events, queues and counts them.
module pulse_sync_rx
  import pulse_sync_rx_pkg::*;
#(
  parameter int MIN_HIGH = 1,
  parameter int MAX_HIGH = 2,
  parameter int PEND_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pulse_sync_rx_if.slave bus
);
  localparam logic [PEND_W-1:0] P_MAX = '1;

  logic              evt, set_short, set_long, busy;
  logic              accept, set_ovf;
  logic              pulse_q;
  logic [PEND_W-1:0] pending_q;
  logic [CNT_W-1:0]  total_q;
  logic              short_q, long_q, ovf_q;

  pulse_width_chk #(
    .MIN_HIGH (MIN_HIGH),
    .MAX_HIGH (MAX_HIGH)
  ) u_chk (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .lvl       (bus.i_sync_lvl),
    .evt       (evt),
    .err_short (set_short),
    .err_long  (set_long),
    .busy      (busy)
  );

  assign accept  = (pending_q != '0) & bus.i_evt_ready;
  assign set_ovf = evt & ~accept & (pending_q == P_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pulse_q   <= 1'b0;
      pending_q <= '0;
      total_q   <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pulse_q <= evt;
      if (evt && !accept && pending_q != P_MAX)
        pending_q <= pending_q + 1'b1;
      else if (accept && !evt)
        pending_q <= pending_q - 1'b1;
      if (evt) total_q <= total_q + 1'b1;
      // a new error on the clearing edge must survive
      short_q <= set_short | (short_q & ~bus.i_err_clr);
      long_q  <= set_long  | (long_q  & ~bus.i_err_clr);
      ovf_q   <= set_ovf   | (ovf_q   & ~bus.i_err_clr);
    end
  end

  assign bus.o_pulse     = pulse_q;
  assign bus.o_evt_valid = (pending_q != '0);
  assign bus.o_pending   = pending_q;
  assign bus.o_total     = total_q;
  assign bus.o_err_short = short_q;
  assign bus.o_err_long  = long_q;
  assign bus.o_err_ovf   = ovf_q;
  assign bus.o_busy      = busy;

endmodule

// File: doc/pulse_sync_rx.md
Name: pulse_sync_rx

Overview:
- Slow-domain receiver placed directly downstream of the fast-to-slow pulse-stretch CDC. Its input is the CDC's synchronized, stretched level.
- Converts each stretched level back into exactly one single-cycle event pulse.
- Checks the high width against the expected stretch window and flags anomalies: glitches, merged source pulses, stuck-high.
- Queues events in a pending counter drained by a valid/ready handshake, and keeps a wrap-around total count.

Parameters:
- MIN_HIGH, 1: minimum number of high samples for a legal event. A shorter width sets o_err_short.
- MAX_HIGH, 2: maximum number of high samples for a legal event. A longer width sets o_err_long.
- PEND_W, 4: width of the pending-event counter. It saturates at 2^PEND_W-1.
- CNT_W, 8: width of the total-event counter. It wraps.

Ports:
- i_clk  in  1  slow-domain clock (same clock as the CDC's synchronizer stage)
- i_rst_n  in  1  synchronous, active-low reset
- i_sync_lvl  in  1  synchronized stretched level from the CDC output
- i_evt_ready  in  1  consumer accepts one pending event
- i_err_clr  in  1  clears all sticky error flags
- o_pulse  out  1  single-cycle pulse per detected event
- o_evt_valid  out  1  high while o_pending != 0
- o_pending  out  PEND_W  events detected but not yet accepted
- o_total  out  CNT_W  total events detected, mod 2^CNT_W
- o_err_short  out  1  sticky: high width < MIN_HIGH
- o_err_long  out  1  sticky: high width > MAX_HIGH
- o_err_ovf  out  1  sticky: event lost because o_pending was saturated
- o_busy  out  1  state != IDLE

Behaviour:
- Clocking and reset:
  - One clock, i_clk. Reset is synchronous, active-low on i_rst_n.
  - While i_rst_n=0 at an edge, all registers clear: o_pulse=0, o_pending=0, o_total=0, all errors 0.
  - FSM resets to WAIT_LOW; the internal previous-level register resets to 1.
- FSM states: WAIT_LOW, IDLE, HIGH. Width counter w saturates at MAX_HIGH+1.
- WAIT_LOW:
  - Masks a level that is already high when reset releases. No pulse, no errors, no counting.
  - Moves to IDLE on the first edge that samples i_sync_lvl=0.
- IDLE:
  - An edge that samples i_sync_lvl=1 sets o_pulse=1 for exactly one cycle after that edge.
  - On that same edge: o_pending increments, o_total increments, w=1, next state HIGH.
  - Latency: one i_clk edge from the first high sample to o_pulse.
- HIGH, each edge that samples 1: w increments (saturating).
  - If w==MAX_HIGH before the increment, o_err_long is set.
  - No further pulse is produced; the FSM stays in HIGH until the level is sampled low.
- HIGH, edge that samples 0: if w<MIN_HIGH, o_err_short is set; next state IDLE.
  - A new rise can be accepted on the edge after the return to IDLE. One low sample between pulses is legal.
- Pending counter, per edge:
  - Event and accept (o_evt_valid & i_evt_ready) together: o_pending unchanged.
  - Event only: o_pending increments. If o_pending is already at maximum, it holds and o_err_ovf is set.
  - Accept only: o_pending decrements.
  - i_evt_ready while o_pending=0 is ignored.
- o_total wraps from 2^CNT_W-1 to 0 with no flag.
- Sticky errors:
  - Each flag holds until i_err_clr=1 or reset.
  - If i_err_clr and a new error condition occur on the same edge, the set wins.
- All outputs are registered. No combinational path from inputs to outputs, except o_evt_valid, which is derived from the registered o_pending.

Decomposition:
- Package pulse_sync_rx_pkg holds the state encoding constants (WAIT_LOW=2'd0, IDLE=2'd1, HIGH=2'd2) and the width helper for the w counter, clog2(MAX_HIGH+2).
- One sub-module, pulse_width_chk: the FSM, w counter and error generation. It outputs an event strobe and error strobes.
- The top level holds the pending/total counters, the sticky flags and the handshake.

Test Plan:
- Reset release with i_sync_lvl=1 held 3 cycles, then 0 → no o_pulse, o_total=0, o_busy=1 until the low sample, then 0.
- Levels of 2 high samples, 2 low samples, repeated 5 times with i_evt_ready=0 → five 1-cycle o_pulse, o_pending=5, o_total=5, no errors.
- i_sync_lvl high for 4 samples (MAX_HIGH=2) → one o_pulse; o_err_long set on the 3rd high edge; i_err_clr then clears it.
- i_evt_ready=0 and 16 events with PEND_W=4 → o_pending stops at 15, o_err_ovf=1, o_total=16. Then event and ready on the same edge → o_pending stays 15, no further overflow.
- 256 events with CNT_W=8 and i_evt_ready=1 → o_total wraps to 0, o_pending=0 after draining.
- Reset asserted mid-HIGH (w=1) then released while the level is still high → counters clear, FSM sits in WAIT_LOW, no pulse until the next low-to-high transition.
